// File: rtl/ks_note_sequencer.sv
// rtl/ks_note_sequencer.sv - step sequencer driving the Karplus-Strong string voice
//
// Purpose: holds a small pattern of string periods and, at a programmable
// tempo, drives the string voice's period and pluck inputs so a melody plays
// without per-note host writes. A zero pattern entry is a rest.
//
// Ports:
//   clk_i        sequencer clock (string-voice clock domain)
//   rst_i        asynchronous, active-high reset
//   run_i        level; rising edge starts the pattern, low aborts it
//   loop_en_i    1 = wrap to step 0 after the last step, 0 = stop
//   length_i     index of the last step played
//   tempo_i      step duration minus 1, in clk_i cycles
//   step_we_i    pattern write strobe
//   step_addr_i  pattern write address
//   step_data_i  period to store (0 = rest)
//   pluck_o      pluck request to the string voice
//   period_o     period to the string voice
//   step_idx_o   index of the step currently playing
//   busy_o       high while playing
//   done_o       one-cycle pulse when a non-looping pattern completes

module ks_note_sequencer #(
  parameter int NUM_STEPS   = 8,
  parameter int STEP_AW     = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int TEMPO_WIDTH = 16,
  parameter int PLUCK_LEN   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   run_i,
  input  logic                   loop_en_i,
  input  logic [STEP_AW-1:0]     length_i,
  input  logic [TEMPO_WIDTH-1:0] tempo_i,
  input  logic                   step_we_i,
  input  logic [STEP_AW-1:0]     step_addr_i,
  input  logic [DATA_WIDTH-1:0]  step_data_i,
  output logic                   pluck_o,
  output logic [DATA_WIDTH-1:0]  period_o,
  output logic [STEP_AW-1:0]     step_idx_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int PCW = $clog2(PLUCK_LEN + 1);
  localparam logic [PCW-1:0] PLUCK_INIT = PCW'(PLUCK_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic [DATA_WIDTH-1:0]   mem [NUM_STEPS];
  logic                    run_q;
  logic [TEMPO_WIDTH-1:0]  tempo_cnt, tempo_d;
  logic [PCW-1:0]          pluck_cnt, pluck_cnt_d;
  logic                    pluck_d, busy_d, done_d;
  logic [DATA_WIDTH-1:0]   period_d;
  logic [STEP_AW-1:0]      idx_d;
  logic                    enter;
  logic [STEP_AW-1:0]      enter_idx;
  logic [DATA_WIDTH-1:0]   entry;
  logic                    start;

  assign start = run_i & ~run_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d     = state;
    pluck_d     = pluck_o;
    period_d    = period_o;
    idx_d       = step_idx_o;
    busy_d      = busy_o;
    done_d      = 1'b0;
    tempo_d     = tempo_cnt;
    pluck_cnt_d = pluck_cnt;
    enter       = 1'b0;
    enter_idx   = '0;
    entry       = '0;

    case (state)
      S_IDLE: begin
        busy_d  = 1'b0;
        pluck_d = 1'b0;
        if (start) begin
          enter     = 1'b1;
          enter_idx = '0;
          state_d   = S_PLAY;
          busy_d    = 1'b1;
        end
      end

      S_PLAY: begin
        if (!run_i) begin
          // Abort wins over pluck timing and step advance.
          state_d = S_IDLE;
          pluck_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          if (pluck_cnt != '0) begin
            pluck_cnt_d = pluck_cnt - PCW'(1);
          end else begin
            pluck_d = 1'b0;
          end

          if (tempo_cnt != '0) begin
            tempo_d = tempo_cnt - TEMPO_WIDTH'(1);
          end else if (step_idx_o != length_i) begin
            // Wraps modulo NUM_STEPS if length_i was lowered mid-pattern.
            enter     = 1'b1;
            enter_idx = step_idx_o + STEP_AW'(1);
          end else if (loop_en_i) begin
            enter     = 1'b1;
            enter_idx = '0;
          end else begin
            state_d = S_DONE;
            pluck_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        pluck_d = 1'b0;
      end
    endcase

    // Step entry reads the pre-edge memory, so a same-edge write to the
    // entered address only shows up on the next visit.
    if (enter) begin
      entry   = mem[enter_idx];
      tempo_d = tempo_i;
      idx_d   = enter_idx;
      if (entry != '0) begin
        period_d    = entry;
        pluck_d     = 1'b1;
        pluck_cnt_d = PLUCK_INIT;
      end else begin
        pluck_d     = 1'b0;
        pluck_cnt_d = '0;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q      <= 1'b0;
      pluck_o    <= 1'b0;
      period_o   <= '0;
      step_idx_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      tempo_cnt  <= '0;
      pluck_cnt  <= '0;
    end else begin
      run_q      <= run_i;
      pluck_o    <= pluck_d;
      period_o   <= period_d;
      step_idx_o <= idx_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      tempo_cnt  <= tempo_d;
      pluck_cnt  <= pluck_cnt_d;
    end
  end

  // Pattern memory; writes accepted in every state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        mem[i] <= '0;
      end
    end else if (step_we_i) begin
      mem[step_addr_i] <= step_data_i;
    end
  end

endmodule

// File: tb/tb_ks_note_sequencer.sv
// tb/tb_ks_note_sequencer.sv - self-checking bench for ks_note_sequencer

module tb_ks_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        run_i;
  logic        loop_en_i;
  logic [2:0]  length_i;
  logic [15:0] tempo_i;
  logic        step_we_i;
  logic [2:0]  step_addr_i;
  logic [7:0]  step_data_i;
  logic        pluck_o;
  logic [7:0]  period_o;
  logic [2:0]  step_idx_o;
  logic        busy_o;
  logic        done_o;

  always #5 clk = ~clk;

  ks_note_sequencer dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .run_i      (run_i),
    .loop_en_i  (loop_en_i),
    .length_i   (length_i),
    .tempo_i    (tempo_i),
    .step_we_i  (step_we_i),
    .step_addr_i(step_addr_i),
    .step_data_i(step_data_i),
    .pluck_o    (pluck_o),
    .period_o   (period_o),
    .step_idx_o (step_idx_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  typedef struct packed {
    logic       pluck;
    logic [7:0] period;
    logic [2:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic [3:0][7:0] pat;
    logic            wr;
    logic [15:0]     tempo;
    logic [2:0]      len;
    logic            lp;
    int              first;
    int              nrows;
    logic            exp_done;
  } scen_t;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] period;
    int         pl;
    int         dur;
  } row_t;

  scen_t scen [7];
  row_t  rows [22];
  obs_t  sb_q [$];

  int total = 0;
  int bad   = 0;

  function automatic obs_t sample();
    obs_t o;
    o.pluck  = pluck_o;
    o.period = period_o;
    o.idx    = step_idx_o;
    o.busy   = busy_o;
    o.done   = done_o;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pluck=%0b period=%0d idx=%0d busy=%0b done=%0b, want pluck=%0b period=%0d idx=%0d busy=%0b done=%0b",
               name, act.pluck, act.period, act.idx, act.busy, act.done,
               exp.pluck, exp.period, exp.idx, exp.busy, exp.done);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_step(input logic [2:0] a, input logic [7:0] d);
    step_we_i   = 1'b1;
    step_addr_i = a;
    step_data_i = d;
    tick();
    step_we_i   = 1'b0;
  endtask

  task automatic set_row(input int i, input logic [2:0] idx, input logic [7:0] per,
                         input int pl, input int dur);
    rows[i].idx    = idx;
    rows[i].period = per;
    rows[i].pl     = pl;
    rows[i].dur    = dur;
  endtask

  task automatic set_scen(input int i, input logic [3:0][7:0] pat, input logic wr,
                          input logic [15:0] tempo, input logic [2:0] len, input logic lp,
                          input int first, input int nrows, input logic exp_done);
    scen[i].pat      = pat;
    scen[i].wr       = wr;
    scen[i].tempo    = tempo;
    scen[i].len      = len;
    scen[i].lp       = lp;
    scen[i].first    = first;
    scen[i].nrows    = nrows;
    scen[i].exp_done = exp_done;
  endtask

  // Expands a scenario's step table into per-cycle expectations, then plays it.
  task automatic run_scenario(input int s);
    obs_t e;
    obs_t got;
    int   rowcyc;
    int   n;
    logic [2:0] last_idx;
    logic [7:0] last_per;
    string nm;

    if (scen[s].wr) begin
      for (int a = 0; a < 4; a++) wr_step(3'(a), scen[s].pat[a]);
    end
    tempo_i   = scen[s].tempo;
    length_i  = scen[s].len;
    loop_en_i = scen[s].lp;

    rowcyc   = 0;
    last_idx = 3'd0;
    last_per = 8'd0;
    for (int r = scen[s].first; r < scen[s].first + scen[s].nrows; r++) begin
      for (int c = 0; c < rows[r].dur; c++) begin
        e.pluck  = (c < rows[r].pl);
        e.period = rows[r].period;
        e.idx    = rows[r].idx;
        e.busy   = 1'b1;
        e.done   = 1'b0;
        sb_q.push_back(e);
        rowcyc++;
      end
      last_idx = rows[r].idx;
      last_per = rows[r].period;
    end
    e.pluck  = 1'b0;
    e.period = last_per;
    e.idx    = last_idx;
    e.busy   = 1'b0;
    e.done   = scen[s].exp_done;
    sb_q.push_back(e);
    if (scen[s].exp_done) begin
      e.done = 1'b0;
      sb_q.push_back(e);
      sb_q.push_back(e);
    end

    run_i = 1'b1;
    n = sb_q.size();
    for (int k = 0; k < n; k++) begin
      tick();
      got = sample();
      nm = $sformatf("scen%0d_cyc%0d", s, k);
      check(nm, got, sb_q.pop_front());
      if (!scen[s].exp_done && k == rowcyc - 1) run_i = 1'b0;
    end
    run_i = 1'b0;
    tick();
  endtask

  initial begin
    obs_t e;
    logic seen_done;

    // single pass, tempo 9
    set_row(0, 3'd0, 8'd40, 4, 10);
    set_row(1, 3'd1, 8'd40, 0, 10);
    set_row(2, 3'd2, 8'd30, 4, 10);
    // loop, aborted after five steps
    set_row(3, 3'd0, 8'd40, 4, 10);
    set_row(4, 3'd1, 8'd40, 0, 10);
    set_row(5, 3'd2, 8'd30, 4, 10);
    set_row(6, 3'd0, 8'd40, 4, 10);
    set_row(7, 3'd1, 8'd40, 0, 10);
    // tempo 1: pluck truncated to 2 cycles
    set_row(8,  3'd0, 8'd40, 2, 2);
    set_row(9,  3'd1, 8'd40, 0, 2);
    set_row(10, 3'd2, 8'd30, 2, 2);
    // back-to-back plucks, tempo 2, four steps
    set_row(11, 3'd0, 8'd40, 3, 3);
    set_row(12, 3'd1, 8'd50, 3, 3);
    set_row(13, 3'd2, 8'd30, 3, 3);
    set_row(14, 3'd3, 8'd60, 3, 3);
    // tempo 0
    set_row(15, 3'd0, 8'd7, 1, 1);
    set_row(16, 3'd1, 8'd7, 0, 1);
    set_row(17, 3'd2, 8'd9, 1, 1);
    // length 0: single step
    set_row(18, 3'd0, 8'd40, 4, 5);
    // after reset: all rests, period stays 0
    set_row(19, 3'd0, 8'd0, 0, 2);
    set_row(20, 3'd1, 8'd0, 0, 2);
    set_row(21, 3'd2, 8'd0, 0, 2);

    set_scen(0, {8'd0, 8'd30, 8'd0, 8'd40}, 1'b1, 16'd9, 3'd2, 1'b0, 0,  3, 1'b1);
    set_scen(1, {8'd0, 8'd30, 8'd0, 8'd40}, 1'b1, 16'd9, 3'd2, 1'b1, 3,  5, 1'b0);
    set_scen(2, {8'd0, 8'd30, 8'd0, 8'd40}, 1'b1, 16'd1, 3'd2, 1'b0, 8,  3, 1'b1);
    set_scen(3, {8'd60, 8'd30, 8'd50, 8'd40}, 1'b1, 16'd2, 3'd3, 1'b0, 11, 4, 1'b1);
    set_scen(4, {8'd0, 8'd9, 8'd0, 8'd7}, 1'b1, 16'd0, 3'd2, 1'b0, 15, 3, 1'b1);
    set_scen(5, {8'd0, 8'd0, 8'd0, 8'd40}, 1'b1, 16'd4, 3'd0, 1'b0, 18, 1, 1'b1);
    set_scen(6, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 16'd1, 3'd2, 1'b0, 19, 3, 1'b1);

    rst_i       = 1'b1;
    run_i       = 1'b0;
    loop_en_i   = 1'b0;
    length_i    = 3'd0;
    tempo_i     = 16'd0;
    step_we_i   = 1'b0;
    step_addr_i = 3'd0;
    step_data_i = 8'd0;

    #1;
    e = '0;
    check("reset_state", sample(), e);
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    tick();
    check("idle_after_reset", sample(), e);

    for (int s = 0; s < 6; s++) run_scenario(s);

    // Write collision: mem[1] 20 -> 55 on the edge that enters step 1.
    wr_step(3'd0, 8'd10);
    wr_step(3'd1, 8'd20);
    wr_step(3'd2, 8'd30);
    tempo_i = 16'd3; length_i = 3'd2; loop_en_i = 1'b1;
    run_i = 1'b1;
    tick();
    e = '{pluck: 1'b1, period: 8'd10, idx: 3'd0, busy: 1'b1, done: 1'b0};
    check("coll_step0", sample(), e);
    repeat (3) tick();
    step_we_i = 1'b1; step_addr_i = 3'd1; step_data_i = 8'd55;
    @(posedge clk);
    @(negedge clk);
    step_we_i = 1'b0;
    e = '{pluck: 1'b1, period: 8'd20, idx: 3'd1, busy: 1'b1, done: 1'b0};
    check("coll_old_value", sample(), e);
    repeat (12) tick();
    e = '{pluck: 1'b1, period: 8'd55, idx: 3'd1, busy: 1'b1, done: 1'b0};
    check("coll_new_value", sample(), e);
    run_i = 1'b0;
    tick();
    e = '{pluck: 1'b0, period: 8'd55, idx: 3'd1, busy: 1'b0, done: 1'b0};
    check("coll_abort", sample(), e);

    // Abort during a plucking step 1: pluck and busy drop on the next edge.
    wr_step(3'd0, 8'd40);
    wr_step(3'd1, 8'd50);
    wr_step(3'd2, 8'd30);
    tempo_i = 16'd9; length_i = 3'd2; loop_en_i = 1'b0;
    run_i = 1'b1;
    repeat (11) tick();
    e = '{pluck: 1'b1, period: 8'd50, idx: 3'd1, busy: 1'b1, done: 1'b0};
    check("abort_before", sample(), e);
    run_i = 1'b0;
    tick();
    e = '{pluck: 1'b0, period: 8'd50, idx: 3'd1, busy: 1'b0, done: 1'b0};
    check("abort_next_edge", sample(), e);
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen_done = 1'b1;
    end
    total++;
    if (seen_done) begin
      bad++;
      $display("FAIL abort_quiet: got done/busy activity after abort, want none");
    end

    // Asynchronous reset mid-play while pluck_o is high.
    tempo_i = 16'd9; length_i = 3'd2; loop_en_i = 1'b1;
    run_i = 1'b1;
    tick();
    e = '{pluck: 1'b1, period: 8'd40, idx: 3'd0, busy: 1'b1, done: 1'b0};
    check("rst_pre_pluck", sample(), e);
    #2 rst_i = 1'b1;
    #1;
    e = '0;
    check("rst_async_clear", sample(), e);
    run_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    tick();

    run_scenario(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
